burst_mem_responder: RTL and testbench
======================================

// Module: burst_mem_responder
// PURPOSE
//  Memory-side responder for the fetch/loader request interface (address, rw, access_size, enable).
//  Services single-word or burst reads and writes of 32-bit words at byte address BASE_ADDR upward.
//  Returns read data on data_out with a one-cycle registered latency.
//  Drives busy while a burst is in progress.
//  Sits between the fetch stage (or program loader) and the word-array storage.
// PARAMETERS
//  DATA_WIDTH  32            data word width
//  ADDR_WIDTH  32            byte address width
//  DEPTH       1024          storage size in words
//  BASE_ADDR   32'h80020000  byte address of word 0
// PORTS
//  clock        in   1   single clock; all state updates on posedge
//  reset_n      in   1   asynchronous, active-low reset
//  address      in   32  byte address of first beat; bits[1:0] ignored
//  data_in      in   32  write data; sampled at each write-beat edge
//  access_size  in   2   00=1 beat, 01=4 beats, 10=8 beats, 11=16 beats
//  rw           in   1   0=write, 1=read
//  enable       in   1   request strobe; sampled only in IDLE
//  busy         out  1   burst has further beats pending; new requests ignored
//  data_out     out  32  registered read data
//  data_valid   out  1   data_out holds a read beat this cycle
//  addr_err     out  1   one-cycle pulse: current beat address out of range
// BEHAVIOUR
//  Reset (async, reset_n=0):
//   state=IDLE; busy=0; data_out=0; data_valid=0; addr_err=0; internal counters=0.
//   Storage array is NOT cleared.
//  Word index:
//   idx = (addr - BASE_ADDR) >> 2, computed in 32 bits with wrap.
//   In range iff addr >= BASE_ADDR and idx < DEPTH.
//  FSM states: IDLE, BURST.
//  IDLE, enable=1 at edge E0:
//   latch rw; cur_addr=address; beats=1/4/8/16.
//   Perform beat 0 at E0.
//   If beats>1: remaining=beats-1, busy<=1, go BURST.
//   Else stay IDLE, busy stays 0.
//  BURST, each edge Ek:
//   cur_addr += 4; perform beat k; remaining -= 1.
//   When remaining reaches 0: busy<=0, go IDLE.
//   enable, rw and access_size are ignored; rw latched at E0 governs the whole burst.
//  Read beat:
//   data_out <= mem[idx]; data_valid <= 1 for the following cycle.
//   Latency is 1 cycle; beats are back-to-back, no gaps.
//  Write beat:
//   mem[idx] <= data_in sampled at that edge; data_valid <= 0; data_out holds its value.
//  Out-of-range beat:
//   read returns data_out <= 0 with data_valid=1; write is dropped.
//   addr_err=1 for that cycle only.
//   Burst continues; it may straddle the end of the array.
//  Timing rules:
//   No beat in a cycle -> data_valid=0, addr_err=0.
//   First edge after burst end with enable=1 starts a new request (0 idle cycles needed).
//   busy=0 throughout a 1-beat access.
//   busy is high for exactly beats-1 cycles.
//  reset_n asserted mid-burst aborts the burst immediately.
//   Already-written beats persist; no further beats are performed.
//  Memory address arithmetic wraps modulo 2^32; no exceptions raised.
// TESTING
//  1. Write 0x27bdfff8 @0x80020000 (size 00), then read same -> data_out=0x27bdfff8, data_valid=1 one cycle after read edge, busy=0.
//  2. 4-beat write 0x1..0x4 @0x80020000, then 4-beat read -> data_out 0x1,0x2,0x3,0x4 on consecutive cycles; busy high 3 cycles.
//  3. 16-beat read @BASE+4*(DEPTH-2) -> beats 0-1 return stored data; beats 2-15 return 0 with addr_err=1 each cycle.
//  4. enable pulsed with rw=0 mid 8-beat read -> ignored; 8 read beats complete; storage unchanged.
//  5. reset_n=0 after beat 2 of a 4-beat write -> busy=0, data_valid=0 at once; words 0-1 updated (beat 2 if its edge preceded reset), word 3 unchanged.
//  6. Back-to-back: 1-beat read, then enable the next cycle -> second data_valid exactly one cycle after the first; no idle gap.

Source files
------------

// File: rtl/burst_mem_responder.sv
// rtl/burst_mem_responder.sv - word-array responder for single/burst fetch and loader accesses
// One beat per edge: beat 0 on the request edge, remaining beats back-to-back while busy.
module burst_mem_responder #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DEPTH      = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h80020000
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [1:0]            access_size,
  input  logic                  rw,
  input  logic                  enable,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  addr_err
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t                  state_q, state_d;
  logic                    rw_q, rw_d;
  logic [ADDR_WIDTH-1:0]   cur_addr_q, cur_addr_d;
  logic [3:0]              remaining_q, remaining_d;
  logic                    busy_q, busy_d;
  logic [DATA_WIDTH-1:0]   data_out_q;
  logic                    data_valid_q;
  logic                    addr_err_q;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    beat_en;
  logic                    beat_rw;
  logic [ADDR_WIDTH-1:0]   beat_addr;
  logic [ADDR_WIDTH-1:0]   beat_offset;
  logic [ADDR_WIDTH-1:0]   beat_idx;
  logic                    in_range;
  logic [IDX_W-1:0]        widx;
  logic [3:0]              beats_m1;

  always_comb begin
    beats_m1 = 4'd0;
    case (access_size)
      2'b00:   beats_m1 = 4'd0;
      2'b01:   beats_m1 = 4'd3;
      2'b10:   beats_m1 = 4'd7;
      default: beats_m1 = 4'd15;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    rw_d        = rw_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    busy_d      = busy_q;
    beat_en     = 1'b0;
    beat_rw     = rw_q;
    beat_addr   = cur_addr_q;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          beat_en     = 1'b1;
          beat_rw     = rw;
          beat_addr   = address;
          rw_d        = rw;
          cur_addr_d  = address;
          remaining_d = beats_m1;
          if (beats_m1 != 4'd0) begin
            busy_d  = 1'b1;
            state_d = S_BURST;
          end
        end
      end
      S_BURST: begin
        // Request inputs are ignored here; the latched direction governs every beat.
        beat_en     = 1'b1;
        beat_addr   = cur_addr_q + ADDR_WIDTH'(4);
        cur_addr_d  = beat_addr;
        remaining_d = remaining_q - 4'd1;
        if (remaining_q == 4'd1) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Offset wraps modulo 2^ADDR_WIDTH; the >= check rejects addresses below the base.
  assign beat_offset = beat_addr - BASE_ADDR;
  assign beat_idx    = beat_offset >> 2;
  assign in_range    = (beat_addr >= BASE_ADDR) && (beat_idx < ADDR_WIDTH'(DEPTH));
  assign widx        = beat_idx[IDX_W-1:0];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      rw_q         <= 1'b0;
      cur_addr_q   <= '0;
      remaining_q  <= '0;
      busy_q       <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rw_q         <= rw_d;
      cur_addr_q   <= cur_addr_d;
      remaining_q  <= remaining_d;
      busy_q       <= busy_d;
      data_valid_q <= beat_en && beat_rw;
      addr_err_q   <= beat_en && !in_range;
      if (beat_en && beat_rw) begin
        data_out_q <= in_range ? mem[widx] : '0;
      end
    end
  end

  // Storage is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clock) begin
    if (reset_n && beat_en && !beat_rw && in_range) begin
      mem[widx] <= data_in;
    end
  end

  assign busy       = busy_q;
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_burst_mem_responder.sv
// tb/tb_burst_mem_responder.sv - directed self-checking bench for burst_mem_responder
module tb_burst_mem_responder;

  localparam logic [31:0] BASE = 32'h80020000;

  logic        clock;
  logic        reset_n;
  logic [31:0] address;
  logic [31:0] data_in;
  logic [1:0]  access_size;
  logic        rw;
  logic        enable;
  logic        busy;
  logic [31:0] data_out;
  logic        data_valid;
  logic        addr_err;

  int checks = 0;
  int errors = 0;

  burst_mem_responder dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .address     (address),
    .data_in     (data_in),
    .access_size (access_size),
    .rw          (rw),
    .enable      (enable),
    .busy        (busy),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .addr_err    (addr_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic r, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    enable      = 1'b1;
    rw          = r;
    access_size = sz;
    address     = a;
    data_in     = d;
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0; rw = 1'b0; access_size = 2'b00;
    address = '0; data_in = '0;
    tick(); tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_data_out", data_out, 32'd0);
    check("rst_valid", {31'd0, data_valid}, 32'd0);
    check("rst_addr_err", {31'd0, addr_err}, 32'd0);
    reset_n = 1'b1;
    tick();

    // 1: single write then single read
    req(1'b0, 2'b00, BASE, 32'h27bdfff8);
    tick();
    check("t1_wr_busy", {31'd0, busy}, 32'd0);
    check("t1_wr_valid", {31'd0, data_valid}, 32'd0);
    req(1'b1, 2'b00, BASE, 32'h0);
    tick();
    enable = 1'b0;
    check("t1_rd_data", data_out, 32'h27bdfff8);
    check("t1_rd_valid", {31'd0, data_valid}, 32'd1);
    check("t1_rd_busy", {31'd0, busy}, 32'd0);
    tick();
    check("t1_idle_valid", {31'd0, data_valid}, 32'd0);
    check("t1_hold_data", data_out, 32'h27bdfff8);

    // 2: 4-beat write 1..4 then 4-beat read
    req(1'b0, 2'b01, BASE, 32'h1);
    for (int k = 0; k < 4; k++) begin
      tick();
      enable  = 1'b0;
      data_in = 32'(k + 2);
      check($sformatf("t2_wr_busy%0d", k), {31'd0, busy}, (k < 3) ? 32'd1 : 32'd0);
    end
    req(1'b1, 2'b01, BASE, 32'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      enable = 1'b0;
      check($sformatf("t2_rd_data%0d", k), data_out, 32'(k + 1));
      check($sformatf("t2_rd_valid%0d", k), {31'd0, data_valid}, 32'd1);
      check($sformatf("t2_rd_busy%0d", k), {31'd0, busy}, (k < 3) ? 32'd1 : 32'd0);
    end
    tick();
    check("t2_end_valid", {31'd0, data_valid}, 32'd0);

    // 3: 16-beat read straddling the array end
    req(1'b0, 2'b00, BASE + 32'd4088, 32'h0000000a);
    tick();
    req(1'b0, 2'b00, BASE + 32'd4092, 32'h0000000b);
    tick();
    check("t3_inrange_wr_err", {31'd0, addr_err}, 32'd0);
    req(1'b0, 2'b00, BASE - 32'd4, 32'hffffffff);
    tick();
    enable = 1'b0;
    check("t3_low_wr_err", {31'd0, addr_err}, 32'd1);
    check("t3_low_wr_valid", {31'd0, data_valid}, 32'd0);
    req(1'b1, 2'b11, BASE + 32'd4088, 32'h0);
    for (int k = 0; k < 16; k++) begin
      tick();
      enable = 1'b0;
      check($sformatf("t3_data%0d", k), data_out, (k == 0) ? 32'ha : (k == 1) ? 32'hb : 32'h0);
      check($sformatf("t3_err%0d", k), {31'd0, addr_err}, (k >= 2) ? 32'd1 : 32'd0);
      check($sformatf("t3_valid%0d", k), {31'd0, data_valid}, 32'd1);
      check($sformatf("t3_busy%0d", k), {31'd0, busy}, (k < 15) ? 32'd1 : 32'd0);
    end
    tick();
    check("t3_end_err", {31'd0, addr_err}, 32'd0);

    // 4: stray write request mid 8-beat read is ignored
    req(1'b0, 2'b10, BASE, 32'h100);
    for (int k = 0; k < 8; k++) begin
      tick();
      enable  = 1'b0;
      data_in = 32'h100 + 32'(k + 1);
    end
    req(1'b1, 2'b10, BASE, 32'h0);
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k == 2) req(1'b0, 2'b00, BASE, 32'hdeadbeef);
      else enable = 1'b0;
      check($sformatf("t4_data%0d", k), data_out, 32'h100 + 32'(k));
      check($sformatf("t4_valid%0d", k), {31'd0, data_valid}, 32'd1);
    end
    req(1'b1, 2'b00, BASE, 32'h0);
    tick();
    enable = 1'b0;
    check("t4_word0_kept", data_out, 32'h100);

    // 5: reset after beat 2 of a 4-beat write
    req(1'b0, 2'b01, BASE + 32'h40, 32'h500);
    for (int k = 0; k < 4; k++) begin
      tick();
      enable  = 1'b0;
      data_in = 32'h500 + 32'(k + 1);
    end
    req(1'b0, 2'b01, BASE + 32'h40, 32'h600);
    for (int k = 0; k < 3; k++) begin
      tick();
      enable  = 1'b0;
      data_in = 32'h600 + 32'(k + 1);
    end
    reset_n = 1'b0;
    #1;
    check("t5_rst_busy", {31'd0, busy}, 32'd0);
    check("t5_rst_valid", {31'd0, data_valid}, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    req(1'b1, 2'b01, BASE + 32'h40, 32'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      enable = 1'b0;
      check($sformatf("t5_data%0d", k), data_out, (k < 3) ? 32'h600 + 32'(k) : 32'h503);
    end

    // 6: back-to-back single reads, no idle gap
    req(1'b1, 2'b00, BASE, 32'h0);
    tick();
    address = BASE + 32'd4;
    check("t6_first_data", data_out, 32'h100);
    check("t6_first_valid", {31'd0, data_valid}, 32'd1);
    tick();
    enable = 1'b0;
    check("t6_second_data", data_out, 32'h101);
    check("t6_second_valid", {31'd0, data_valid}, 32'd1);
    tick();
    check("t6_after_valid", {31'd0, data_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
